fetch_pc_gen: RTL and testbench

Parametrised fetch-address generator at the head of the front end.
- Holds the current fetch-block PC and presents it to the fetch stage with a valid/ready handshake.
- Advances to the next aligned fetch block on each accepted request.
- Accepts up to NUM_REDIRECT prioritised redirect sources (e.g. backend flush, branch resolve, predictor).
- Tags every request with an epoch so downstream stages can drop stale fetches after a redirect.

---
 rtl/fetch_pc_pkg.sv | 48 ++++
 rtl/redirect_arbiter.sv | 40 ++++
 rtl/fetch_pc_gen.sv | 136 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_pkg
//  Purpose  : Shared types, default parameter values and helper functions for
//             the fetch-address generator (fetch_pc_gen) and its arbiter.
//  Contents : fetch_pc_state_e  - generator FSM states
//             c_def_*           - default parameter values
//             clog2()           - ceiling log2 for offset widths
//             next_block_pc()   - first byte of the following aligned block
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pc_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } fetch_pc_state_e;

    localparam int          c_def_pc_width          = 32;
    localparam int          c_def_fetch_bytes       = 8;
    localparam int          c_def_num_redirect      = 3;
    localparam int          c_def_epoch_width       = 3;
    localparam logic [31:0] c_def_init_pc           = 32'h8000_0000;
    localparam int          c_def_reset_hold_cycles = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Computed at 64 bits so any PC_WIDTH up to 64 can truncate the result;
    // the carry out of the top block is dropped by the caller's truncation.
    function automatic logic [63:0] next_block_pc(input logic [63:0] pc,
                                                  input int          fetch_bytes);
        logic [63:0] size;
        size = 64'(fetch_bytes);
        return (pc & ~(size - 64'd1)) + size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/redirect_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : redirect_arbiter
//  Purpose  : Fixed-priority select over the redirect sources; index 0 wins.
//             Purely combinational.
//  Ports    : i_valid [NUM_REDIRECT]           per-source request
//             i_pc    [NUM_REDIRECT][PC_WIDTH] per-source target
//             o_any                            at least one request
//             o_grant [NUM_REDIRECT]           one-hot winner (0 if none)
//             o_pc    [PC_WIDTH]               winner's target (0 if none)
//  Revision : 1.0 - initial release
// ============================================================================
module redirect_arbiter #(
    parameter int NUM_REDIRECT = 3,
    parameter int PC_WIDTH     = 32
) (
    input  logic [NUM_REDIRECT-1:0]               i_valid,
    input  logic [NUM_REDIRECT-1:0][PC_WIDTH-1:0] i_pc,
    output logic                                  o_any,
    output logic [NUM_REDIRECT-1:0]               o_grant,
    output logic [PC_WIDTH-1:0]                   o_pc
);

    // Scan from the lowest priority upwards so the last hit is the winner.
    always_comb begin
        o_any   = 1'b0;
        o_grant = '0;
        o_pc    = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                o_any      = 1'b1;
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_pc       = i_pc[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_gen
//  Purpose  : Fetch-address generator. Holds the fetch-block PC, presents it
//             with valid/ready, advances to the next aligned block on accept,
//             and takes prioritised redirects that bump an epoch tag.
//  Ports    : i_clk, i_rst_n (async, active low)
//             i_redirect_valid/i_redirect_pc  redirect sources (0 = highest)
//             i_ready                         fetch stage accepts request
//             o_valid, o_pc, o_epoch          current request
//             o_block_bytes                   bytes from o_pc to block end
//             o_redirect_grant                one-hot source taken last cycle
//  Options  : FETCH_PC_GEN_REDIRECT_BUBBLE_EN - a redirect taken while running
//             drops o_valid for one cycle before the target is presented.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pc_pkg::*;
#(
    parameter int                  PC_WIDTH          = c_def_pc_width,
    parameter int                  FETCH_BYTES       = c_def_fetch_bytes,
    parameter int                  NUM_REDIRECT      = c_def_num_redirect,
    parameter int                  EPOCH_WIDTH       = c_def_epoch_width,
    parameter logic [PC_WIDTH-1:0] INIT_PC           = PC_WIDTH'(c_def_init_pc),
    parameter int                  RESET_HOLD_CYCLES = c_def_reset_hold_cycles
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [NUM_REDIRECT-1:0]               i_redirect_valid,
    input  logic [NUM_REDIRECT-1:0][PC_WIDTH-1:0] i_redirect_pc,
    input  logic                                  i_ready,
    output logic                                  o_valid,
    output logic [PC_WIDTH-1:0]                   o_pc,
    output logic [clog2(FETCH_BYTES):0]           o_block_bytes,
    output logic [EPOCH_WIDTH-1:0]                o_epoch,
    output logic [NUM_REDIRECT-1:0]               o_redirect_grant
);

    localparam int OFF_W  = clog2(FETCH_BYTES);
    localparam int BB_W   = OFF_W + 1;
    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? clog2(RESET_HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] c_hold_init = HOLD_W'(RESET_HOLD_CYCLES);

    fetch_pc_state_e         r_state;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [EPOCH_WIDTH-1:0]  r_epoch;
    logic                    r_valid;
    logic [NUM_REDIRECT-1:0] r_grant;

    logic                    w_any;
    logic [NUM_REDIRECT-1:0] w_grant;
    logic [PC_WIDTH-1:0]     w_sel_pc;
    logic [PC_WIDTH-1:0]     w_seq_pc;
    logic                    w_fire;

    redirect_arbiter #(
        .NUM_REDIRECT (NUM_REDIRECT),
        .PC_WIDTH     (PC_WIDTH)
    ) u_arb (
        .i_valid (i_redirect_valid),
        .i_pc    (i_redirect_pc),
        .o_any   (w_any),
        .o_grant (w_grant),
        .o_pc    (w_sel_pc)
    );

    assign w_fire   = r_valid & i_ready;
    assign w_seq_pc = PC_WIDTH'(next_block_pc(64'(r_pc), FETCH_BYTES));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= HOLD;
            r_hold_cnt <= c_hold_init;
            r_pc       <= INIT_PC;
            r_epoch    <= '0;
            r_valid    <= 1'b0;
            r_grant    <= '0;
        end else begin
            r_grant <= w_any ? w_grant : '0;

            // A redirect overrides the sequential step even when the current
            // request is accepted in the same cycle.
            if (w_any) begin
                r_pc    <= w_sel_pc;
                r_epoch <= r_epoch + EPOCH_WIDTH'(1);
            end else if (w_fire) begin
                r_pc    <= w_seq_pc;
            end

            case (r_state)
                HOLD: begin
                    // Leaving on the edge where the count is 1 (or 0) gives
                    // exactly RESET_HOLD_CYCLES invalid cycles after release.
                    if (r_hold_cnt <= HOLD_W'(1)) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
`ifdef FETCH_PC_GEN_REDIRECT_BUBBLE_EN
                RUN: begin
                    if (w_any) begin
                        r_state <= BUBBLE;
                        r_valid <= 1'b0;
                    end
                end
                BUBBLE: begin
                    // Another redirect restarts the one-cycle bubble.
                    if (!w_any) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end
                end
`else
                RUN: begin
                    r_valid <= 1'b1;
                end
`endif
                default: begin
                    r_state <= HOLD;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid          = r_valid;
    assign o_pc             = r_pc;
    assign o_epoch          = r_epoch;
    assign o_redirect_grant = r_grant;
    assign o_block_bytes    = BB_W'(FETCH_BYTES) - {1'b0, r_pc[OFF_W-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_pc_gen
//  Purpose  : Self-checking bench for fetch_pc_gen with default parameters.
//             A behavioural model tracks PC, epoch, grant and valid from the
//             external rules; a per-cycle compare plus directed literal
//             expectations check the design. Honors
//             FETCH_PC_GEN_REDIRECT_BUBBLE_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam int N  = 3;
    localparam int FB = 8;
    localparam int H  = 2;
    localparam int HOLD_LEN = (H > 0) ? H : 1;
    localparam logic [31:0] INIT = 32'h8000_0000;
`ifdef FETCH_PC_GEN_REDIRECT_BUBBLE_EN
    localparam bit c_bubble = 1'b1;
`else
    localparam bit c_bubble = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          rv = '0;
    logic [N-1:0][31:0]    rpc = '0;
    logic                  ready = 1'b0;
    logic                  o_valid;
    logic [31:0]           o_pc;
    logic [3:0]            o_block_bytes;
    logic [2:0]            o_epoch;
    logic [N-1:0]          o_grant;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_gen dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_redirect_valid (rv),
        .i_redirect_pc    (rpc),
        .i_ready          (ready),
        .o_valid          (o_valid),
        .o_pc             (o_pc),
        .o_block_bytes    (o_block_bytes),
        .o_epoch          (o_epoch),
        .o_redirect_grant (o_grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic [2:0]  m_epoch;
    logic [N-1:0] m_grant;
    logic        m_valid;
    int          m_edges;

    int          win;
    logic [31:0] n_pc;
    logic [2:0]  n_epoch;
    logic [N-1:0] n_grant;
    logic        n_valid;

    always_comb begin
        win = -1;
        for (int i = 0; i < N; i++) begin
            if (rv[i] && win < 0) win = i;
        end
        n_pc    = m_pc;
        n_epoch = m_epoch;
        n_grant = '0;
        if (win >= 0) begin
            n_pc       = rpc[win];
            n_epoch    = 3'((int'(m_epoch) + 1) % 8);
            n_grant[win] = 1'b1;
        end else if (m_valid && ready) begin
            n_pc = ((m_pc / 32'(FB)) + 32'd1) * 32'(FB);
        end
        n_valid = ((m_edges + 1) >= HOLD_LEN) &&
                  !(c_bubble && (win >= 0) && (m_edges >= HOLD_LEN));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= INIT;
            m_epoch <= '0;
            m_grant <= '0;
            m_valid <= 1'b0;
            m_edges <= 0;
        end else begin
            m_pc    <= n_pc;
            m_epoch <= n_epoch;
            m_grant <= n_grant;
            m_valid <= n_valid;
            m_edges <= m_edges + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", 64'(o_valid), 64'(m_valid));
            chk("cyc_pc", 64'(o_pc), 64'(m_pc));
            chk("cyc_epoch", 64'(o_epoch), 64'(m_epoch));
            chk("cyc_grant", 64'(o_grant), 64'(m_grant));
            chk("cyc_block_bytes", 64'(o_block_bytes), 64'(32'(FB) - (m_pc % 32'(FB))));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        if (c_bubble) step();
    endtask

    initial begin
        step();
        cmp_en = 1'b1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_pc", 64'(o_pc), 64'h8000_0000);
        chk("rst_epoch", 64'(o_epoch), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);
        step();

        // Release with ready high: two invalid cycles, then sequential blocks.
        ready = 1'b1;
        rst_n = 1'b1;
        step();
        chk("hold_valid", 64'(o_valid), 64'd0);
        step();
        chk("run_valid", 64'(o_valid), 64'd1);
        chk("seq_pc0", 64'(o_pc), 64'h8000_0000);
        step();
        chk("seq_pc1", 64'(o_pc), 64'h8000_0008);
        step();
        chk("seq_pc2", 64'(o_pc), 64'h8000_0010);
        chk("seq_epoch", 64'(o_epoch), 64'd0);

        // Stall for four cycles, then accept exactly once.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_pc", 64'(o_pc), 64'h8000_0010);
            chk("stall_valid", 64'(o_valid), 64'd1);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("unstall_pc", 64'(o_pc), 64'h8000_0018);
        step();
        chk("once_pc", 64'(o_pc), 64'h8000_0018);

        // Redirect on source 1 to an unaligned target, with fire.
        ready  = 1'b1;
        rv     = 3'b010;
        rpc[1] = 32'h0000_1003;
        step();
        rv = '0;
        chk("redir_pc", 64'(o_pc), 64'h1003);
        chk("redir_bb", 64'(o_block_bytes), 64'd5);
        chk("redir_epoch", 64'(o_epoch), 64'd1);
        chk("redir_grant", 64'(o_grant), 64'b010);
        chk("redir_valid", 64'(o_valid), c_bubble ? 64'd0 : 64'd1);
        settle();
        step();
        chk("after_redir_pc", 64'(o_pc), 64'h1008);
        chk("grant_clear", 64'(o_grant), 64'd0);

        // Sources 0 and 2 together: source 0 wins, epoch bumps once.
        rv     = 3'b101;
        rpc[0] = 32'h0000_2000;
        rpc[2] = 32'h0000_3000;
        step();
        rv = '0;
        chk("prio_pc", 64'(o_pc), 64'h2000);
        chk("prio_grant", 64'(o_grant), 64'b001);
        chk("prio_epoch", 64'(o_epoch), 64'd2);
        settle();

        // Top-of-space wrap: sequential step silently goes to 0.
        rv     = 3'b100;
        rpc[2] = 32'hFFFF_FFF8;
        step();
        rv = '0;
        chk("top_pc", 64'(o_pc), 64'hFFFF_FFF8);
        settle();
        step();
        chk("wrap_pc", 64'(o_pc), 64'h0);
        chk("wrap_epoch", 64'(o_epoch), 64'd3);
        chk("wrap_bb", 64'(o_block_bytes), 64'd8);

        // Eight back-to-back redirects: epoch 3 -> 7 -> 0 -> 3.
        for (int i = 0; i < 8; i++) begin
            rv        = '0;
            rv[i % N] = 1'b1;
            rpc[i % N] = 32'h0000_4000 + 32'(i * 4);
            step();
            if (i == 3) chk("epoch_at7", 64'(o_epoch), 64'd7);
            if (i == 4) chk("epoch_wrap0", 64'(o_epoch), 64'd0);
        end
        rv = '0;
        chk("epoch_back3", 64'(o_epoch), 64'd3);
        chk("burst_pc", 64'(o_pc), 64'h401C);
        settle();

        // Mid-stream asynchronous reset at 0x1008.
        rv     = 3'b001;
        rpc[0] = 32'h0000_1003;
        step();
        rv = '0;
        settle();
        step();
        chk("pre_rst_pc", 64'(o_pc), 64'h1008);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(o_valid), 64'd0);
        chk("async_pc", 64'(o_pc), 64'h8000_0000);
        chk("async_epoch", 64'(o_epoch), 64'd0);
        rv     = 3'b011;
        rpc[0] = 32'h0000_7000;
        step();
        chk("rst_ignore_pc", 64'(o_pc), 64'h8000_0000);

        // Redirect during HOLD: pc/epoch move, hold length unchanged.
        rst_n  = 1'b1;
        rv     = 3'b001;
        rpc[0] = 32'h0000_5000;
        step();
        rv = '0;
        chk("hold_redir_valid", 64'(o_valid), 64'd0);
        chk("hold_redir_pc", 64'(o_pc), 64'h5000);
        chk("hold_redir_epoch", 64'(o_epoch), 64'd1);
        step();
        chk("hold_exit_valid", 64'(o_valid), 64'd1);
        chk("hold_exit_pc", 64'(o_pc), 64'h5000);
        step();
        chk("hold_seq_pc", 64'(o_pc), 64'h5008);

        // Redirect in RUN: with the bubble option, one invalid cycle first.
        rv     = 3'b010;
        rpc[1] = 32'h0000_6000;
        step();
        rv = '0;
        chk("run_redir_pc", 64'(o_pc), 64'h6000);
        chk("run_redir_epoch", 64'(o_epoch), 64'd2);
        chk("run_redir_valid", 64'(o_valid), c_bubble ? 64'd0 : 64'd1);
        settle();
        chk("present_valid", 64'(o_valid), 64'd1);
        chk("present_pc", 64'(o_pc), 64'h6000);
        step();
        chk("present_seq_pc", 64'(o_pc), 64'h6008);

        step();
        step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
